// File: rtl/contador_pkg.sv
// Shared definitions for the contador counter and its command controller:
// counter mode encodings, controller states and default sizing.
package contador_pkg;

   localparam logic [1:0] MODE_0    = 2'b00;
   localparam logic [1:0] MODE_1    = 2'b01;
   localparam logic [1:0] MODE_2    = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam int DEF_WRAP_W   = 8;
   localparam int DEF_LOAD_TMO = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      LOAD_WAIT = 3'd2,
      RUN       = 3'd3,
      DONE      = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/contador_wrapcnt.sv
// Saturating event counter with synchronous clear, plus a flag telling the
// caller that the increment about to happen lands exactly on the target.
module contador_wrapcnt #(
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              inc,
   input  logic [WRAP_W-1:0] target,
   output logic [WRAP_W-1:0] count,
   output logic [WRAP_W-1:0] count_next,
   output logic              hit
);

   logic [WRAP_W-1:0] sat_inc;

   // Holding at all-ones keeps a runaway rco stream from looking like a fresh start.
   assign sat_inc = (&count) ? count : count + 1'b1;
   assign hit     = inc && (sat_inc == target);

   always_comb begin
      count_next = count;
      if (clr) begin
         count_next = '0;
      end else if (inc) begin
         count_next = sat_inc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/contador_ctrl.sv
// Command controller for the 4-bit contador: seeds it through load mode,
// waits for the load handshake, runs it and counts rco events to a target.
module contador_ctrl
   import contador_pkg::*;
#(
   parameter int WRAP_W   = DEF_WRAP_W,
   parameter int LOAD_TMO = DEF_LOAD_TMO
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_mode,
   input  logic [3:0]        cmd_seed,
   input  logic [WRAP_W-1:0] cmd_wraps,
   input  logic              abort,
   output logic              ctr_enable,
   output logic [1:0]        ctr_mode,
   output logic [3:0]        ctr_D,
   input  logic              ctr_load,
   input  logic              ctr_rco,
   input  logic [3:0]        ctr_Q,
   output logic              busy,
   output logic              done,
   output logic              err_cmd,
   output logic              err_tmo,
   output logic [WRAP_W-1:0] wrap_count,
   output logic [WRAP_W+3:0] snapshot
);

   localparam int TMO_W = $clog2(LOAD_TMO + 1);

   ctrl_state_t       state_reg, state_next;
   logic [TMO_W-1:0]  tmo_reg, tmo_next, tmo_inc;
   logic [1:0]        mode_reg;
   logic [WRAP_W-1:0] wraps_reg;
   logic [WRAP_W-1:0] wc_next;
   logic              wc_clr, wc_inc, wc_hit;
   logic              accept;
   logic              err_cmd_next, err_tmo_next;

   assign accept  = (state_reg == IDLE) && cmd_valid && (cmd_mode != MODE_LOAD);
   assign tmo_inc = tmo_reg + 1'b1;

   contador_wrapcnt #(.WRAP_W(WRAP_W)) u_wrapcnt (
      .clk        (clk),
      .reset      (reset),
      .clr        (wc_clr),
      .inc        (wc_inc),
      .target     (wraps_reg),
      .count      (wrap_count),
      .count_next (wc_next),
      .hit        (wc_hit)
   );

   always_comb begin
      state_next   = state_reg;
      tmo_next     = tmo_reg;
      wc_clr       = 1'b0;
      wc_inc       = 1'b0;
      err_cmd_next = 1'b0;
      err_tmo_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = LOAD;
               wc_clr     = 1'b1;
            end else if (cmd_valid) begin
               err_cmd_next = 1'b1;
            end
         end
         LOAD: begin
            state_next = LOAD_WAIT;
            tmo_next   = '0;
         end
         LOAD_WAIT: begin
            tmo_next = tmo_inc;
            // A load seen on the last allowed cycle still wins over the timeout.
            if (ctr_load) begin
               state_next = (wraps_reg == '0) ? DONE : RUN;
            end else if (tmo_inc == TMO_W'(LOAD_TMO)) begin
               state_next   = IDLE;
               err_tmo_next = 1'b1;
            end
         end
         RUN: begin
            wc_inc = ctr_rco;
            if (abort || wc_hit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Every output is registered from the upcoming state so it lines up with that state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         tmo_reg    <= '0;
         mode_reg   <= MODE_0;
         wraps_reg  <= '0;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         ctr_enable <= 1'b0;
         ctr_mode   <= MODE_0;
         ctr_D      <= '0;
         done       <= 1'b0;
         err_cmd    <= 1'b0;
         err_tmo    <= 1'b0;
         snapshot   <= '0;
      end else begin
         state_reg  <= state_next;
         tmo_reg    <= tmo_next;
         cmd_ready  <= (state_next == IDLE);
         busy       <= (state_next != IDLE);
         ctr_enable <= (state_next == RUN);
         done       <= (state_next == DONE);
         err_cmd    <= err_cmd_next;
         err_tmo    <= err_tmo_next;
         if (accept) begin
            mode_reg  <= cmd_mode;
            wraps_reg <= cmd_wraps;
            ctr_mode  <= MODE_LOAD;
            ctr_D     <= cmd_seed;
         end else if ((state_next == LOAD_WAIT) || (state_next == RUN)) begin
            ctr_mode <= mode_reg;
         end
         if (state_next == DONE) begin
            snapshot <= {wc_next, ctr_Q};
         end
      end
   end

endmodule

// File: tb/tb_contador_ctrl.sv
// Directed bench for contador_ctrl with a small contador stand-in and a
// cycle-level behavioural model checked against the DUT on every falling edge.
module tb_contador_ctrl;

   localparam int W   = 8;
   localparam int TMO = 4;

   logic         clk;
   logic         reset;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_mode;
   logic [3:0]   cmd_seed;
   logic [W-1:0] cmd_wraps;
   logic         abort;
   logic         ctr_enable;
   logic [1:0]   ctr_mode;
   logic [3:0]   ctr_D;
   logic         ctr_load;
   logic         ctr_rco;
   logic [3:0]   ctr_Q;
   logic         busy;
   logic         done;
   logic         err_cmd;
   logic         err_tmo;
   logic [W-1:0] wrap_count;
   logic [W+3:0] snapshot;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;
   int load_dly = 1;
   int lcnt;

   contador_ctrl #(.WRAP_W(W), .LOAD_TMO(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_seed   (cmd_seed),
      .cmd_wraps  (cmd_wraps),
      .abort      (abort),
      .ctr_enable (ctr_enable),
      .ctr_mode   (ctr_mode),
      .ctr_D      (ctr_D),
      .ctr_load   (ctr_load),
      .ctr_rco    (ctr_rco),
      .ctr_Q      (ctr_Q),
      .busy       (busy),
      .done       (done),
      .err_cmd    (err_cmd),
      .err_tmo    (err_tmo),
      .wrap_count (wrap_count),
      .snapshot   (snapshot)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counter stand-in: load answers load_dly cycles after mode 11 is seen (0 = never).
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         lcnt     <= 0;
         ctr_load <= 1'b0;
         ctr_Q    <= 4'd0;
      end else begin
         int n;
         n = (ctr_mode == 2'b11) ? 1 : ((lcnt != 0) ? lcnt + 1 : 0);
         lcnt     <= n;
         ctr_load <= (load_dly != 0) && (n == load_dly);
         if (ctr_mode == 2'b11) ctr_Q <= ctr_D;
         else if (ctr_enable) ctr_Q <= (ctr_mode == 2'b01) ? ctr_Q - 4'd1 : ctr_Q + 4'd1;
      end
   end

   // Behavioural model: tracks a command by its age and phase flags.
   bit           act = 0, running = 0, ending = 0, fin = 0;
   int           age = 0, waited = 0;
   logic [1:0]   m_mode = 2'b00;
   logic [W-1:0] m_wraps = '0;
   logic         e_ready = 1'b1, e_busy = 1'b0, e_en = 1'b0;
   logic         e_done = 1'b0, e_err_cmd = 1'b0, e_err_tmo = 1'b0;
   logic [1:0]   e_mode = 2'b00;
   logic [3:0]   e_D = 4'd0;
   logic [W-1:0] e_wc = '0;
   logic [W+3:0] e_snap = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         act = 0; running = 0; ending = 0; age = 0; waited = 0;
         e_ready = 1'b1; e_busy = 1'b0; e_en = 1'b0; e_mode = 2'b00; e_D = 4'd0;
         e_done = 1'b0; e_err_cmd = 1'b0; e_err_tmo = 1'b0; e_wc = '0; e_snap = '0;
      end else begin
         fin = 0; e_done = 1'b0; e_err_cmd = 1'b0; e_err_tmo = 1'b0;
         if (!act) begin
            if (cmd_valid && cmd_mode == 2'b11) begin
               e_err_cmd = 1'b1;
            end else if (cmd_valid) begin
               act = 1; age = 0; running = 0; ending = 0; waited = 0;
               m_mode = cmd_mode; m_wraps = cmd_wraps; e_wc = '0; e_D = cmd_seed;
            end
         end else if (ending) begin
            act = 0;
         end else if (age >= 2 && !running) begin
            waited++;
            if (ctr_load) begin
               if (m_wraps == 0) begin ending = 1; fin = 1; end
               else running = 1;
            end else if (waited == TMO) begin
               act = 0; e_err_tmo = 1'b1;
            end
         end else if (running) begin
            if (ctr_rco && e_wc != {W{1'b1}}) e_wc = e_wc + 1'b1;
            if (abort || (ctr_rco && e_wc == m_wraps)) begin ending = 1; fin = 1; end
         end
         if (act) age++;
         if (fin) begin e_done = 1'b1; e_snap = {e_wc, ctr_Q}; end
         e_ready = !act;
         e_busy  = act;
         e_en    = act && running && !ending;
         if (act) e_mode = (age == 1) ? 2'b11 : m_mode;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act_v, exp_v, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cmd_ready",  32'(cmd_ready),  32'(e_ready));
         chk("busy",       32'(busy),       32'(e_busy));
         chk("ctr_enable", 32'(ctr_enable), 32'(e_en));
         chk("ctr_mode",   32'(ctr_mode),   32'(e_mode));
         chk("ctr_D",      32'(ctr_D),      32'(e_D));
         chk("done",       32'(done),       32'(e_done));
         chk("err_cmd",    32'(err_cmd),    32'(e_err_cmd));
         chk("err_tmo",    32'(err_tmo),    32'(e_err_tmo));
         chk("wrap_count", 32'(wrap_count), 32'(e_wc));
         chk("snapshot",   32'(snapshot),   32'(e_snap));
      end
   end

   task automatic send(input logic [1:0] m, input logic [3:0] s, input logic [W-1:0] w);
      int k;
      k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
      cmd_valid = 1'b1; cmd_mode = m; cmd_seed = s; cmd_wraps = w;
      $display("cmd mode=%0d seed=%0h wraps=%0d load_dly=%0d t=%0t", m, s, w, load_dly, $time);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic lat_to_enable(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!ctr_enable && n < 30);
   endtask

   task automatic pulse_rco();
      ctr_rco = 1'b1;
      @(negedge clk);
      ctr_rco = 1'b0;
   endtask

   initial begin
      int n, done_at, tmo_at;
      bit en_seen, done_seen;
      cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_seed = 4'd0; cmd_wraps = '0;
      abort = 1'b0; ctr_rco = 1'b0;
      reset = 1'b1;
      #3 reset = 1'b0;
      cmp_en = 1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_enable", 32'(ctr_enable), 0);
      chk("rst_snapshot", 32'(snapshot), 0);

      // 1: normal run, three rco events
      send(2'b00, 4'h5, 8'd3);
      @(negedge clk);
      chk("t1_load_mode", 32'(ctr_mode), 3);
      chk("t1_load_D", 32'(ctr_D), 5);
      lat_to_enable(n);
      chk("t1_latency", n + 1, 3);
      pulse_rco(); @(negedge clk);
      pulse_rco(); @(negedge clk);
      pulse_rco();
      chk("t1_done", 32'(done), 1);
      chk("t1_snap_wraps", 32'(snapshot[W+3:4]), 3);
      chk("t1_enable_off", 32'(ctr_enable), 0);

      // 2: zero wraps goes straight to done after the load handshake
      send(2'b10, 4'h7, 8'd0);
      done_at = 0; en_seen = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (done && done_at == 0) done_at = i;
         if (ctr_enable) en_seen = 1;
      end
      chk("t2_done_at", done_at, 3);
      chk("t2_no_enable", 32'(en_seen), 0);
      chk("t2_wrap_count", 32'(wrap_count), 0);

      // 3: illegal mode rejected
      send(2'b11, 4'h9, 8'd4);
      @(negedge clk);
      chk("t3_err_cmd", 32'(err_cmd), 1);
      chk("t3_ready", 32'(cmd_ready), 1);
      chk("t3_busy", 32'(busy), 0);
      chk("t3_mode_held", 32'(ctr_mode), 2);
      @(negedge clk);
      chk("t3_err_cmd_once", 32'(err_cmd), 0);

      // 4: counter never answers load
      load_dly = 0;
      send(2'b01, 4'h9, 8'd5);
      tmo_at = 0; done_seen = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (err_tmo && tmo_at == 0) tmo_at = i;
         if (done) done_seen = 1;
      end
      chk("t4_tmo_at", tmo_at, 6);
      chk("t4_no_done", 32'(done_seen), 0);
      chk("t4_ready", 32'(cmd_ready), 1);
      load_dly = 1;

      // 5: abort after two rco events
      send(2'b00, 4'h0, 8'd10);
      lat_to_enable(n);
      pulse_rco(); @(negedge clk);
      pulse_rco(); @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5_done", 32'(done), 1);
      chk("t5_wrap_count", 32'(wrap_count), 2);
      chk("t5_enable_off", 32'(ctr_enable), 0);

      // 5b: abort during LOAD ignored; abort with rco counts that rco
      send(2'b01, 4'h3, 8'd10);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      lat_to_enable(n);
      chk("t5b_abort_ignored", n, 1);
      pulse_rco();
      ctr_rco = 1'b1; abort = 1'b1;
      @(negedge clk);
      ctr_rco = 1'b0; abort = 1'b0;
      chk("t5b_done", 32'(done), 1);
      chk("t5b_wrap_count", 32'(wrap_count), 2);

      // slow load answers, including one on the last allowed cycle
      for (int d = 3; d <= 4; d++) begin
         load_dly = d;
         send(2'b00, 4'h1, 8'd1);
         lat_to_enable(n);
         chk("lat_slow_load", n, 2 + d);
         pulse_rco();
         chk("lat_slow_done", 32'(done), 1);
      end
      load_dly = 1;

      // 6: asynchronous reset in RUN
      send(2'b10, 4'h8, 8'd10);
      lat_to_enable(n);
      pulse_rco();
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t6_enable_now", 32'(ctr_enable), 0);
      chk("t6_busy_now", 32'(busy), 0);
      chk("t6_wrap_now", 32'(wrap_count), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t6_ready_after", 32'(cmd_ready), 1);
      chk("t6_wrap_after", 32'(wrap_count), 0);
      send(2'b00, 4'h2, 8'd1);
      lat_to_enable(n);
      pulse_rco();
      chk("t6_recover_done", 32'(done), 1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
